mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit for the MIPS core: a five-state Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath select and write enable, including the immediate extender's `EXTOp`. It takes opcode/funct from the instruction register and the ALU zero flag. It retires one instruction per 2–5 cycles, depending on instruction class.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; forces state to FETCH.
- `op` in 6: IR[31:26], stable from DCD through the end of the instruction.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU result == 0.
- `PCWr` out 1: PC write enable.
- `IRWr` out 1: IR write enable.
- `RFWr` out 1: register file write enable.
- `DMWr` out 1: data memory write enable.
- `EXTOp` out 2: 00 zero-extend, 01 sign-extend, 10 load-upper.
- `ALUOp` out 3: 000 add, 001 sub, 010 or.
- `ALUSrc` out 1: 0 = register B, 1 = extended immediate.
- `NPCOp` out 2: 00 PC+4, 01 branch (PC+4 + sext(imm)<<2), 10 jump target, 11 register rs.
- `RegDst` out 2: 00 rt, 01 rd, 10 $31.
- `WDSel` out 2: 00 ALU result, 01 memory data, 10 PC (already PC+4).
- `state` out 3: current state, for debug.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.

## Operation
- Supported instructions (op/funct):
  - addu 000000/100001; subu 000000/100011; jr 000000/001000.
  - ori 001101; lw 100011; sw 101011; beq 000100; lui 001111; j 000010; jal 000011.
  - Anything else is illegal.
- State encoding: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. Codes 5–7 go to FETCH with all enables 0.
- FETCH: IRWr=1, PCWr=1, NPCOp=00. Next state is DCD.
- DCD:
  - j: PCWr=1, NPCOp=10, then FETCH.
  - jal: PCWr=1, NPCOp=10, RFWr=1, RegDst=10, WDSel=10, then FETCH.
  - jr: PCWr=1, NPCOp=11, then FETCH.
  - Illegal: no writes, instr_done=1, then FETCH (skip).
  - All other instructions go to EXE.
- EXE:
  - beq: ALUOp=001, ALUSrc=0, NPCOp=01, PCWr=zero, then FETCH.
  - lw/sw: ALUOp=000, ALUSrc=1, then MEM.
  - addu/subu/ori/lui go to WB.
- MEM:
  - sw: DMWr=1, then FETCH.
  - lw: go to WB.
- WB: RFWr=1, then FETCH.
  - RegDst: 01 for R-type, else 00.
  - WDSel: 01 for lw, else 00.
- Static decode, held from DCD through the last state of the instruction:
  - EXTOp: 01 for lw/sw/beq; 10 for lui; 00 otherwise.
  - ALUOp: 001 for subu/beq; 010 for ori/lui; 000 otherwise.
  - ALUSrc: 1 for ori/lui/lw/sw.
- Outputs not listed for a state are 0 (enables) or 00/000 (selects).
- instr_done is 1 in the terminal state of each instruction: DCD for j/jal/jr/illegal, EXE for beq, MEM for sw, WB otherwise.

## Timing
- Moore outputs: combinational from `state`, `op`, `funct`, `zero`. Only `state` is registered.
- Instruction latency in cycles: j/jal/jr/illegal 2, beq 3, addu/subu/ori/lui/sw 4, lw 5.
- Reset assertion, any cycle including mid-instruction:
  - state=0 immediately (asynchronous).
  - All enables 0, all selects 0 while reset is high, including IRWr/PCWr that FETCH would normally drive.
  - instr_done=0.
- First FETCH enables take effect in the first cycle after reset falls. The first IR/PC write happens on the following rising edge.
- beq not taken: PCWr=0 in EXE; PC keeps the PC+4 value written in FETCH.
- `zero` is sampled only in EXE for beq.

## Test plan
- Reset: hold reset 3 cycles with op=100011. Required: state=0, PCWr=IRWr=RFWr=DMWr=0, instr_done=0. After release, cycle 1 has state=0, IRWr=PCWr=1; cycle 2 has state=1.
- lw (op=100011): state sequence 0,1,2,3,4. In EXE, EXTOp=01, ALUSrc=1, ALUOp=000. In WB, RFWr=1, WDSel=01, RegDst=00, instr_done=1. DMWr is 0 throughout.
- beq (op=000100) run twice, once with zero=1 and once with zero=0: sequence 0,1,2. In EXE, NPCOp=01, ALUOp=001, EXTOp=01, and PCWr=1 for the taken case, 0 for the not-taken case.
- jal (op=000011) then addu (000000/100001):
  - jal: DCD shows PCWr=1, RFWr=1, RegDst=10, WDSel=10, NPCOp=10; next state 0.
  - addu: WB shows RegDst=01, RFWr=1, ALUOp=000.
- Illegal op=111111 and lui op=001111:
  - Illegal: 2 cycles, no writes in DCD, instr_done=1.
  - lui: EXTOp=10, ALUOp=010, ALUSrc=1, then WB.
- Reset asserted mid-MEM of sw (between clock edges): state=0 and DMWr=0 immediately, with no further DMWr pulse. The FSM restarts at FETCH after release.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DCD/EXE/MEM/WB and drives all
// datapath enables and selects as Moore outputs of state plus decoded opcode.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] EXTOp,
  output logic [2:0] ALUOp,
  output logic       ALUSrc,
  output logic [1:0] NPCOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       instr_done
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    DCD   = 3'd1,
    EXE   = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4
  } state_t;

  state_t cur, nxt;

  logic is_r, i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_lui, i_j, i_jal;
  logic legal;
  logic [1:0] ext_d;
  logic [2:0] alu_d;
  logic       src_d;

  assign is_r   = (op == 6'b000000);
  assign i_addu = is_r && (funct == 6'b100001);
  assign i_subu = is_r && (funct == 6'b100011);
  assign i_jr   = is_r && (funct == 6'b001000);
  assign i_ori  = (op == 6'b001101);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_lui  = (op == 6'b001111);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);
  assign legal  = i_addu | i_subu | i_jr | i_ori | i_lw | i_sw | i_beq |
                  i_lui | i_j | i_jal;

  // Static decode, presented from DCD until the instruction retires
  always_comb begin
    ext_d = 2'b00;
    if (i_lw || i_sw || i_beq) ext_d = 2'b01;
    else if (i_lui)            ext_d = 2'b10;
    alu_d = 3'b000;
    if (i_subu || i_beq)       alu_d = 3'b001;
    else if (i_ori || i_lui)   alu_d = 3'b010;
    src_d = i_ori | i_lui | i_lw | i_sw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt        = FETCH;
    PCWr       = 1'b0;
    IRWr       = 1'b0;
    RFWr       = 1'b0;
    DMWr       = 1'b0;
    EXTOp      = 2'b00;
    ALUOp      = 3'b000;
    ALUSrc     = 1'b0;
    NPCOp      = 2'b00;
    RegDst     = 2'b00;
    WDSel      = 2'b00;
    instr_done = 1'b0;
    // Reset masks FETCH's enables so nothing is written while it is held
    if (!reset) begin
      case (cur)
        FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
          nxt  = DCD;
        end
        DCD: begin
          EXTOp  = ext_d;
          ALUOp  = alu_d;
          ALUSrc = src_d;
          if (i_j || i_jal) begin
            PCWr       = 1'b1;
            NPCOp      = 2'b10;
            instr_done = 1'b1;
            if (i_jal) begin
              RFWr   = 1'b1;
              RegDst = 2'b10;
              WDSel  = 2'b10;
            end
          end else if (i_jr) begin
            PCWr       = 1'b1;
            NPCOp      = 2'b11;
            instr_done = 1'b1;
          end else if (!legal) begin
            instr_done = 1'b1;
          end else begin
            nxt = EXE;
          end
        end
        EXE: begin
          EXTOp  = ext_d;
          ALUOp  = alu_d;
          ALUSrc = src_d;
          if (i_beq) begin
            NPCOp      = 2'b01;
            PCWr       = zero;
            instr_done = 1'b1;
          end else if (i_lw || i_sw) begin
            nxt = MEM;
          end else begin
            nxt = WB;
          end
        end
        MEM: begin
          EXTOp  = ext_d;
          ALUOp  = alu_d;
          ALUSrc = src_d;
          if (i_sw) begin
            DMWr       = 1'b1;
            instr_done = 1'b1;
          end else begin
            nxt = WB;
          end
        end
        WB: begin
          EXTOp      = ext_d;
          ALUOp      = alu_d;
          ALUSrc     = src_d;
          RFWr       = 1'b1;
          RegDst     = is_r ? 2'b01 : 2'b00;
          WDSel      = i_lw ? 2'b01 : 2'b00;
          instr_done = 1'b1;
        end
        default: nxt = FETCH;
      endcase
    end
  end

endmodule
